// File: rtl/multu_hilo_pkg.sv
// Shared funct encodings, FSM state type and the shift-add step used by multu_hilo.
// The ALU and the control decoder use the same funct constants.
package multu_hilo_pkg;

    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [4:0] LAST_STEP = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One shift-add step: the 33-bit sum's carry becomes the new bit 63 after the shift.
    function automatic logic [63:0] shiftAddStep(input logic [63:0] prod,
                                                 input logic [31:0] mcand,
                                                 input logic        addEn);
        logic [32:0] sum;
        sum = {1'b0, prod[63:32]} + {1'b0, (addEn ? mcand : 32'd0)};
        return {sum, prod[31:1]};
    endfunction

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// HI/LO architectural register pair with async active-low clear and the MFHI/MFLO readout mux.
// Readout is combinational so dataOut can join the execute-stage result mux directly.
module hilo_reg
    import multu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [5:0]  i_funct,
    output logic [31:0] o_dataOut
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (i_we) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
        end
    end

    always_comb begin
        o_dataOut = 32'd0;
        case (i_funct)
            FUNCT_MFHI: o_dataOut = r_hi;
            FUNCT_MFLO: o_dataOut = r_lo;
            default:    o_dataOut = 32'd0;
        endcase
    end

endmodule

// File: rtl/multu_hilo.sv
// Multi-cycle 32x32 unsigned shift-add multiplier feeding HI/LO, alongside the ALU.
// busy holds off upstream issue while a product is being formed; done pulses once it lands.
module multu_hilo
    import multu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;
    logic [4:0]  r_count;
    logic        w_accept;
    logic        w_final;
    logic [63:0] w_stepProd;

    assign w_stepProd = shiftAddStep(r_prod, r_mcand, r_mplier[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // MULTU is only accepted when idle or finishing, so a running multiply is never re-latched.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Signal == FUNCT_MULTU) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == LAST_STEP) begin
                    w_final     = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Signal == FUNCT_MULTU) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_prod   <= 64'd0;
            r_count  <= 5'd0;
        end else if (w_accept) begin
            r_mcand  <= dataA;
            r_mplier <= dataB;
            r_prod   <= 64'd0;
            r_count  <= 5'd0;
        end else if (r_state == ST_RUN) begin
            r_prod   <= w_stepProd;
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_count  <= r_count + 5'd1;
        end
    end

    // HI/LO take the final step's result directly, so they never expose a partial product.
    hilo_reg u_hilo (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_final),
        .i_hi      (w_stepProd[63:32]),
        .i_lo      (w_stepProd[31:0]),
        .i_funct   (Signal),
        .o_dataOut (dataOut)
    );

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_multu_hilo.sv
// Scoreboard bench for multu_hilo: stimulus pushes the expected 64-bit product,
// a monitor pops and compares it whenever done pulses.
module tb_multu_hilo;
    import multu_hilo_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          passes = 0;
    logic [63:0] expQ[$];
    logic [31:0] curHi = 32'd0;
    logic [31:0] curLo = 32'd0;

    multu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (reset && done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 64'd1, 64'd0);
            end else begin
                checkOutput("productHiLo", {dut.u_hilo.r_hi, dut.u_hilo.r_lo}, expQ.pop_front());
            end
        end
    end

    // Issue one MULTU; called just after a falling edge, returns #1 after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        dataA  = a;
        dataB  = b;
        Signal = FUNCT_MULTU;
        expQ.push_back(64'(a) * 64'(b));
        @(posedge clk);
        #1;
        Signal = FUNCT_AND;
        dataA  = $urandom;
        dataB  = $urandom;
    endtask

    task automatic waitDone(output int n, output int busyCnt);
        n       = 0;
        busyCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (done) return;
            if (busy) busyCnt++;
        end
        checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic readBack(input string tag);
        Signal = FUNCT_MFLO;
        #1 checkOutput({tag, "_MFLO"}, {32'd0, dataOut}, {32'd0, curLo});
        Signal = FUNCT_MFHI;
        #1 checkOutput({tag, "_MFHI"}, {32'd0, dataOut}, {32'd0, curHi});
        Signal = FUNCT_AND;
        #1;
    endtask

    initial begin
        int          n;
        int          busyCnt;
        int          sawDone;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic [5:0]  others[5];

        others[0] = FUNCT_AND;
        others[1] = FUNCT_OR;
        others[2] = FUNCT_ADD;
        others[3] = FUNCT_SUB;
        others[4] = FUNCT_SLT;

        reset  = 1'b0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = FUNCT_AND;

        // Case 1: reset
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("resetBusy", {63'd0, busy}, 64'd0);
        checkOutput("resetDone", {63'd0, done}, 64'd0);
        readBack("reset");

        // Case 2: 3 x 5, busy for 32 cycles and a single done pulse
        @(negedge clk);
        applyStimulus(32'd3, 32'd5);
        waitDone(n, busyCnt);
        checkOutput("latency3x5", 64'(n), 64'd33);
        checkOutput("busyCycles3x5", 64'(busyCnt), 64'd32);
        curHi = 32'd0;
        curLo = 32'd15;
        readBack("p3x5");
        @(negedge clk);
        checkOutput("donePulseOnce", {63'd0, done}, 64'd0);
        checkOutput("idleNotBusy", {63'd0, busy}, 64'd0);

        // Case 3: all-ones operands exercise the carry-out path
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(n, busyCnt);
        curHi = 32'hFFFFFFFE;
        curLo = 32'h00000001;
        readBack("pOnes");

        // Case 4: zero operand, then back-to-back MULTU accepted in DONE
        @(negedge clk);
        applyStimulus(32'h12345678, 32'd0);
        waitDone(n, busyCnt);
        curHi = 32'd0;
        curLo = 32'd0;
        readBack("pZero");
        applyStimulus(32'h80000000, 32'd2);
        waitDone(n, busyCnt);
        checkOutput("backToBackLatency", 64'(n), 64'd33);
        curHi = 32'd1;
        curLo = 32'd0;
        readBack("pB2B");

        // Case 5: MULTU and MFHI during RUN must not disturb the multiply
        @(negedge clk);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        dataA  = 32'd7;
        dataB  = 32'd7;
        Signal = FUNCT_MULTU;
        @(negedge clk);
        Signal = FUNCT_MFHI;
        #1 checkOutput("mfhiDuringRun", {32'd0, dataOut}, {32'd0, curHi});
        Signal = FUNCT_AND;
        waitDone(n, busyCnt);
        checkOutput("noRestartLatency", 64'(n), 64'd27);
        curHi = 32'hFFFFFFFE;
        curLo = 32'h00000001;
        readBack("pNoRestart");

        // Case 6: reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        applyStimulus($urandom, $urandom | 32'h1);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", {63'd0, busy}, 64'd0);
        curHi = 32'd0;
        curLo = 32'd0;
        readBack("abort");
        expQ.delete();
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        sawDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1;
        end
        checkOutput("noDoneAfterAbort", 64'(sawDone), 64'd0);
        readBack("afterAbort");
        @(negedge clk);
        applyStimulus(32'd2, 32'd3);
        waitDone(n, busyCnt);
        curHi = 32'd0;
        curLo = 32'd6;
        readBack("p2x3");

        // Randomized multiplies, mixing idle gaps, back-to-back issue and other funct codes
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 4) a = 32'd0;
            if (i == 7) b = 32'hFFFFFFFF;
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                Signal = others[$urandom_range(0, 4)];
                #1 checkOutput("otherFunctOut", {32'd0, dataOut}, 64'd0);
                checkOutput("otherFunctBusy", {63'd0, busy}, 64'd0);
                @(negedge clk);
            end
            applyStimulus(a, b);
            waitDone(n, busyCnt);
            checkOutput("randLatency", 64'(n), 64'd33);
            p     = 64'(a) * 64'(b);
            curHi = p[63:32];
            curLo = p[31:0];
            readBack("rand");
        end

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
